// File: rtl/bioee_vector_readback.sv
// Vector capture buffer: samples the vector input bus (optionally decimated)
// and serves the words to the host over a block-throttled pipe-out.
//
// Ports:
//   vectorclk, vectorreset_n        clock, synchronous active-low reset
//   capture_start / capture_stop    1-cycle control pulses
//   decim                           sample every decim+1 cycles
//   vectorinput                     16-bit bus to sample
//   btpipeO_vector_read / _block    host pop strobe / block-start strobe
//   btpipeO_vector_data / _ready    FWFT head word / >= one block buffered
//   capture_active                  high in CAPTURE or FLUSH
//   overflow / underflow            sticky drop / read-while-empty flags
//   sample_count / block_count      accepted samples / host block strobes
module bioee_vector_readback #(
  parameter int          DEPTH       = 1024,
  parameter int          BLOCK_WORDS = 256,
  parameter logic [15:0] PAD_WORD    = 16'hFFFF
) (
  input  logic        vectorclk,
  input  logic        vectorreset_n,
  input  logic        capture_start,
  input  logic        capture_stop,
  input  logic [15:0] decim,
  input  logic [15:0] vectorinput,
  input  logic        btpipeO_vector_read,
  input  logic        btpipeO_vector_block,
  output logic [15:0] btpipeO_vector_data,
  output logic        btpipeO_vector_ready,
  output logic        capture_active,
  output logic        overflow,
  output logic        underflow,
  output logic [31:0] sample_count,
  output logic [15:0] block_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BLOCK_WORDS);

  localparam logic [AW:0]   L_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_BLK  = (AW+1)'(BLOCK_WORDS);
  localparam logic [AW:0]   L_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] L_PONE = AW'(1);
  localparam logic [BW-1:0] L_FONE = BW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAPT = 2'd1;
  localparam logic [1:0] S_FLSH = 2'd2;

  logic [1:0]    r_state;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_dcnt;
  logic [BW-1:0] r_fill;
  logic [15:0]   r_data;
  logic          r_ready;
  logic          r_ovf;
  logic          r_udf;
  logic [31:0]   r_scnt;
  logic [15:0]   r_bcnt;

  logic          w_full;
  logic          w_empty;
  logic          w_start;
  logic          w_tick;
  logic          w_samp;
  logic          w_drop;
  logic          w_aligned;
  logic          w_pad;
  logic          w_wr;
  logic [15:0]   w_wdata;
  logic          w_pop;
  logic          w_udf;
  logic [AW-1:0] w_rd_nxt;
  logic [AW:0]   w_count_n;
  logic [15:0]   w_data_n;

  assign w_full    = (r_count == L_FULL);
  assign w_empty   = (r_count == '0);
  assign w_start   = (r_state == S_IDLE) && capture_start;
  assign w_tick    = (r_state == S_CAPT) && (r_dcnt == 16'd0);
  assign w_samp    = w_tick && !w_full;
  assign w_drop    = w_tick && w_full;
  // r_fill counts words written since start modulo the block size
  assign w_aligned = (r_fill == '0);
  // pads stall (not drop) while the buffer is full
  assign w_pad     = (r_state == S_FLSH) && !w_aligned && !w_full;
  assign w_wr      = w_samp || w_pad;
  assign w_wdata   = w_pad ? PAD_WORD : vectorinput;
  assign w_pop     = btpipeO_vector_read && !w_empty;
  assign w_udf     = btpipeO_vector_read && w_empty;
  assign w_rd_nxt  = r_rd_ptr + L_PONE;

  always_comb begin
    w_count_n = r_count;
    if (w_wr && !w_pop) begin
      w_count_n = r_count + L_ONE;
    end else if (!w_wr && w_pop) begin
      w_count_n = r_count - L_ONE;
    end
  end

  // Next head word. When the popped word was the last one stored,
  // the word being written this cycle (if any) becomes the head;
  // with nothing left the output holds its last value.
  always_comb begin
    w_data_n = r_data;
    if (w_pop) begin
      if (r_count > L_ONE) begin
        w_data_n = r_mem[w_rd_nxt];
      end else if (w_wr) begin
        w_data_n = w_wdata;
      end
    end else if (w_empty && w_wr) begin
      w_data_n = w_wdata;
    end
  end

  always_ff @(posedge vectorclk) begin
    if (vectorreset_n && w_wr) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge vectorclk) begin
    if (!vectorreset_n) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dcnt   <= '0;
      r_fill   <= '0;
      r_data   <= '0;
      r_ready  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_scnt   <= '0;
      r_bcnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (capture_start) r_state <= S_CAPT;
        S_CAPT: if (capture_stop) r_state <= S_FLSH;
        S_FLSH: if (w_aligned) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_start) begin
        r_dcnt <= '0;
      end else if (r_state == S_CAPT) begin
        // decim is picked up only at reload
        r_dcnt <= (r_dcnt == 16'd0) ? decim : r_dcnt - 16'd1;
      end

      if (w_start) begin
        r_scnt <= '0;
      end else if (w_samp) begin
        r_scnt <= r_scnt + 32'd1;
      end

      if (w_start) begin
        r_fill <= '0;
      end else if (w_wr) begin
        r_fill <= r_fill + L_FONE;
      end

      if (w_start) r_ovf <= 1'b0;
      if (w_drop) r_ovf <= 1'b1;
      if (w_start) r_udf <= 1'b0;
      if (w_udf) r_udf <= 1'b1;

      if (w_wr) r_wr_ptr <= r_wr_ptr + L_PONE;
      if (w_pop) r_rd_ptr <= w_rd_nxt;
      r_count <= w_count_n;
      r_data  <= w_data_n;
      r_ready <= (w_count_n >= L_BLK);

      if (btpipeO_vector_block) r_bcnt <= r_bcnt + 16'd1;
    end
  end

  assign btpipeO_vector_data  = r_data;
  assign btpipeO_vector_ready = r_ready;
  assign capture_active       = (r_state != S_IDLE);
  assign overflow             = r_ovf;
  assign underflow            = r_udf;
  assign sample_count         = r_scnt;
  assign block_count          = r_bcnt;

endmodule

// File: tb/tb_bioee_vector_readback.sv
// Randomized bench for bioee_vector_readback against a queue-based
// model of the capture buffer, plus directed capture/flush scenarios.
module tb_bioee_vector_readback;

  localparam int DEPTH = 1024;
  localparam int BLK   = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] dec;
  logic [15:0] vin;
  logic        rd;
  logic        blk;
  logic [15:0] data;
  logic        ready;
  logic        active;
  logic        ovf;
  logic        udf;
  logic [31:0] scnt;
  logic [15:0] bcnt;

  bioee_vector_readback dut (
    .vectorclk            (clk),
    .vectorreset_n        (rst_n),
    .capture_start        (start),
    .capture_stop         (stop),
    .decim                (dec),
    .vectorinput          (vin),
    .btpipeO_vector_read  (rd),
    .btpipeO_vector_block (blk),
    .btpipeO_vector_data  (data),
    .btpipeO_vector_ready (ready),
    .capture_active       (active),
    .overflow             (ovf),
    .underflow            (udf),
    .sample_count         (scnt),
    .block_count          (bcnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // reference model: buffer is a queue, mode 0 idle / 1 capture / 2 flush
  logic [15:0] q[$];
  logic [15:0] m_data;
  logic [31:0] m_sc;
  logic [15:0] m_bc;
  bit          m_ovf, m_udf, m_ready;
  int          mode, m_dcnt, m_wtot;

  task automatic model_reset();
    q.delete();
    m_data = 0; m_sc = 0; m_bc = 0;
    m_ovf = 0; m_udf = 0; m_ready = 0;
    mode = 0; m_dcnt = 0; m_wtot = 0;
  endtask

  task automatic model_step();
    int pre;
    bit wr;
    bit aligned;
    logic [15:0] w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pre = q.size();
    wr = 0;
    w = 0;
    if (mode == 0 && start) begin
      m_sc = 0; m_ovf = 0; m_udf = 0; m_wtot = 0; m_dcnt = 0;
    end
    aligned = (m_wtot % BLK) == 0;
    if (mode == 1) begin
      if (m_dcnt == 0) begin
        if (pre < DEPTH) begin
          wr = 1; w = vin; m_sc++; m_wtot++;
        end else begin
          m_ovf = 1;
        end
        m_dcnt = dec;
      end else begin
        m_dcnt--;
      end
    end else if (mode == 2 && !aligned && pre < DEPTH) begin
      wr = 1; w = 16'hFFFF; m_wtot++;
    end
    if (rd) begin
      if (pre > 0) void'(q.pop_front());
      else m_udf = 1;
    end
    if (wr) q.push_back(w);
    if (q.size() > 0) m_data = q[0];
    if (blk) m_bc++;
    case (mode)
      0: if (start) mode = 1;
      1: if (stop) mode = 2;
      default: if (aligned) mode = 0;
    endcase
    m_ready = q.size() >= BLK;
  endtask

  task automatic check_outs();
    chk("data", data, m_data);
    chk("ready", ready, m_ready);
    chk("active", active, mode != 0);
    chk("overflow", ovf, m_ovf);
    chk("underflow", udf, m_udf);
    chk("sample_count", scnt, m_sc);
    chk("block_count", bcnt, m_bc);
  endtask

  task automatic cyc(input bit s, input bit p, input bit r, input bit b,
                     input logic [15:0] v);
    start = s; stop = p; rd = r; blk = b; vin = v;
    @(posedge clk);
    model_step();
    #1;
    check_outs();
  endtask

  task automatic flush_wait(input string tag);
    for (int n = 0; n < 1200 && active; n++) cyc(0, 0, 0, 0, 16'h0);
    chk(tag, active, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 2000 && q.size() > 0; n++) cyc(0, 0, 1, 0, 16'h0);
    chk(tag, q.size(), 0);
  endtask

  initial begin
    logic [15:0] first;
    logic [15:0] held;
    int i;
    rst_n = 0; start = 0; stop = 0; rd = 0; blk = 0;
    dec = 0; vin = 0;
    model_reset();
    cyc(0, 0, 0, 0, 16'h0);
    cyc(0, 0, 0, 0, 16'h0);
    rst_n = 1;
    cyc(0, 0, 0, 0, 16'h0);

    // 1: ramp of 300 samples, pads to 512
    dec = 0;
    cyc(1, 0, 0, 0, 16'h0);
    for (int k = 0; k < 300; k++) cyc(0, k == 299, 0, 0, 16'(k));
    flush_wait("t1_flush_end");
    chk("t1_sc", scnt, 300);
    chk("t1_ready", ready, 1'b1);
    i = 0;
    for (int n = 0; n < 3000 && i < 512; n++) begin
      bit r;
      r = 1'($urandom_range(0, 1));
      if (r) begin
        chk("t1_word", data, (i < 300) ? i : 32'hFFFF);
        i++;
      end
      cyc(0, 0, r, 0, 16'h0);
    end
    chk("t1_nread", i, 512);
    chk("t1_ready_low", ready, 1'b0);

    // 2: decim 3 for 40 cycles -> 10 samples
    dec = 3;
    cyc(1, 0, 0, 0, 16'h0);
    for (int k = 0; k < 40; k++) cyc(0, k == 39, 0, 0, 16'($urandom));
    flush_wait("t2_flush_end");
    chk("t2_sc", scnt, 10);
    chk("t2_words", q.size(), 256);
    drain("t2_drain");

    // 3: overflow with no reads
    dec = 0;
    cyc(1, 0, 0, 0, 16'h0);
    first = 16'($urandom);
    cyc(0, 0, 0, 0, first);
    for (int k = 1; k < 1100; k++) cyc(0, k == 1099, 0, 0, 16'($urandom));
    chk("t3_ovf", ovf, 1'b1);
    chk("t3_sc", scnt, 1024);
    flush_wait("t3_flush_end");
    chk("t3_first", data, first);
    drain("t3_drain");

    // 4: read on empty
    held = data;
    cyc(0, 0, 1, 0, 16'h0);
    cyc(0, 0, 1, 1, 16'h0);
    chk("t4_udf", udf, 1'b1);
    chk("t4_hold", data, held);
    cyc(1, 0, 0, 0, 16'h0);
    chk("t4_udf_clr", udf, 1'b0);
    cyc(0, 1, 0, 0, 16'h1234);
    flush_wait("t4_flush_end");
    drain("t4_drain");

    // 5: reset mid-capture with 100 words buffered
    cyc(1, 0, 0, 0, 16'h0);
    for (int k = 0; k < 100; k++) cyc(0, 0, 0, 0, 16'($urandom));
    rst_n = 0;
    cyc(0, 0, 0, 0, 16'h0);
    chk("t5_data", data, 0);
    chk("t5_active", active, 0);
    chk("t5_sc", scnt, 0);
    rst_n = 1;
    cyc(0, 0, 0, 0, 16'h0);
    cyc(0, 0, 0, 0, 16'h0);
    chk("t5_no_pads", ready, 0);

    // 6: start+stop together, stop next cycle -> 1 sample + 255 pads
    cyc(1, 1, 0, 0, 16'h0);
    chk("t6_capture", active, 1'b1);
    cyc(0, 1, 0, 0, 16'h00AA);
    flush_wait("t6_flush_end");
    i = 0;
    for (int n = 0; n < 600 && q.size() > 0; n++) begin
      chk("t6_word", data, (i == 0) ? 32'h00AA : 32'hFFFF);
      cyc(0, 0, 1, 0, 16'h0);
      i++;
    end
    chk("t6_words", i, 256);

    // random traffic
    for (int n = 0; n < 5000; n++) begin
      bit s, p, r, b;
      if ($urandom_range(0, 49) == 0) dec = 16'($urandom_range(0, 3));
      s = ($urandom_range(0, 299) == 0);
      p = ($urandom_range(0, 149) == 0);
      r = !s && ($urandom_range(0, 9) < 4);
      b = ($urandom_range(0, 19) == 0);
      cyc(s, p, r, b, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
